// File: rtl/iecdrv_pkg.sv
// rtl/iecdrv_pkg.sv - shared types, constants and ROM address mask for the drive ROM scheduler
package iecdrv_pkg;

  localparam int NDR_MAX = 4;

  localparam logic [1:0] ROM_SZ_8K  = 2'b00;
  localparam logic [1:0] ROM_SZ_16K = 2'b01;
  localparam logic [1:0] ROM_SZ_32K = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } sched_state_t;

  // Bits above the fitted ROM size are forced low; the standard ROM always needs bit 13.
  function automatic logic [14:0] rom_mask_addr(input logic [14:0] a,
                                                input logic [1:0]  sz,
                                                input logic        stdrom);
    rom_mask_addr = {a[14] & sz[1], a[13] & (sz[0] | stdrom), a[12:0]};
  endfunction

endpackage

// File: rtl/iecdrv_sched_tagpipe.sv
// rtl/iecdrv_sched_tagpipe.sv - valid/index shift register that tracks outstanding ROM reads
module iecdrv_sched_tagpipe #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [1:0] in_idx,
  output logic       out_valid,
  output logic [1:0] out_idx,
  output logic       any_valid
);

  logic [DEPTH-1:0] r_v;
  logic [1:0]       r_idx [DEPTH];

  // Shift one stage per cycle; a flush drops every outstanding read at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) r_idx[i] <= 2'd0;
    end else if (flush) begin
      r_v <= '0;
    end else begin
      r_v[0]   <= in_valid;
      r_idx[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_v[i]   <= r_v[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_idx   = r_idx[DEPTH-1];
  assign any_valid = |r_v;

endmodule

// File: rtl/iecdrv_rom_sched.sv
// rtl/iecdrv_rom_sched.sv - shares one drive ROM read port among up to four drives; optional IECDRV_ROM_SCHED_OVERRUN_EN
import iecdrv_pkg::*;

module iecdrv_rom_sched #(
  parameter int NDR     = 2,
  parameter int AW      = 15,
  parameter int ROM_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ph2_f,
  input  logic [NDR-1:0] drv_en,
  input  logic [AW-1:0]  drv_addr [NDR],
  input  logic [1:0]     rom_sz,
  input  logic           stdrom,
  output logic [AW-1:0]  rom_a,
  input  logic [7:0]     rom_q,
  output logic [7:0]     drv_data [NDR],
  output logic [NDR-1:0] drv_valid,
  output logic           busy,
  output logic           done,
  output logic [0:0]     overrun,
  output logic [7:0]     overrun_cnt
);

  sched_state_t   r_state;
  logic [NDR-1:0] r_pend;
  logic [AW-1:0]  r_addr [NDR];
  logic           r_busy;
  logic           r_done;

  logic           w_abort;
  logic [NDR-1:0] w_pend_nxt;
  logic [1:0]     w_sel_idx;
  logic [AW-1:0]  w_sel_addr;
  logic [AW-1:0]  w_mask_addr;
  logic           w_push;
  logic           w_out_valid;
  logic [1:0]     w_out_idx;
  logic           w_pipe_any;

  assign w_abort = ph2_f & r_busy;
  assign w_push  = (r_state == ISSUE) & ~ph2_f;

  // Pick the lowest-index drive still waiting for its slot in this round.
  always_comb begin
    w_pend_nxt = r_pend;
    w_sel_idx  = 2'd0;
    w_sel_addr = r_addr[0];
    for (int i = NDR - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel_idx  = 2'(i);
        w_sel_addr = r_addr[i];
      end
    end
    for (int i = 0; i < NDR; i++) begin
      if (w_sel_idx == 2'(i)) w_pend_nxt[i] = 1'b0;
    end
  end

  assign w_mask_addr = AW'(rom_mask_addr(15'(w_sel_addr), rom_sz, stdrom));

  // Round sequencing: snapshot on ph2_f (restarting any round in flight), issue, then drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      rom_a   <= '0;
      for (int i = 0; i < NDR; i++) r_addr[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (ph2_f) begin
        r_pend  <= drv_en;
        r_busy  <= 1'b1;
        r_state <= (|drv_en) ? ISSUE : DRAIN;
        for (int i = 0; i < NDR; i++) r_addr[i] <= drv_addr[i];
      end else begin
        case (r_state)
          ISSUE: begin
            rom_a  <= w_mask_addr;
            r_pend <= w_pend_nxt;
            if (w_pend_nxt == '0) r_state <= DRAIN;
          end
          DRAIN: begin
            if (!w_pipe_any) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  iecdrv_sched_tagpipe #(
    .DEPTH (ROM_LAT + 1)
  ) u_tagpipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (w_abort),
    .in_valid  (w_push),
    .in_idx    (w_sel_idx),
    .out_valid (w_out_valid),
    .out_idx   (w_out_idx),
    .any_valid (w_pipe_any)
  );

  // Land the ROM byte for the read leaving the tag pipe; an abort suppresses it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drv_valid <= '0;
      for (int i = 0; i < NDR; i++) drv_data[i] <= 8'h00;
    end else begin
      drv_valid <= '0;
      for (int i = 0; i < NDR; i++) begin
        if (w_out_valid && !w_abort && (w_out_idx == 2'(i))) begin
          drv_data[i]  <= rom_q;
          drv_valid[i] <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;

`ifdef IECDRV_ROM_SCHED_OVERRUN_EN
  logic       r_overrun;
  logic [7:0] r_overrun_cnt;

  // Sticky abort flag and saturating abort count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun     <= 1'b0;
      r_overrun_cnt <= 8'h00;
    end else if (w_abort) begin
      r_overrun <= 1'b1;
      if (r_overrun_cnt != 8'hFF) r_overrun_cnt <= r_overrun_cnt + 8'h01;
    end
  end

  assign overrun     = r_overrun;
  assign overrun_cnt = r_overrun_cnt;
`else
  assign overrun     = 1'b0;
  assign overrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_iecdrv_rom_sched.sv
// tb/tb_iecdrv_rom_sched.sv - scoreboard bench for iecdrv_rom_sched
module tb_iecdrv_rom_sched;

`ifdef IECDRV_ROM_SCHED_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ph2_f = 1'b0;
  logic [3:0]  drv_en = 4'h0;
  logic [14:0] drv_addr [4];
  logic [1:0]  rom_sz = 2'b11;
  logic        stdrom = 1'b0;
  logic [14:0] rom_a;
  logic [7:0]  rom_q = 8'h00;
  logic [7:0]  drv_data [4];
  logic [3:0]  drv_valid;
  logic        busy;
  logic        done;
  logic [0:0]  overrun;
  logic [7:0]  overrun_cnt;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;

  typedef struct {
    int kind;
    int idx;
    int data;
    int t;
  } ev_t;
  ev_t sb[$];

  iecdrv_rom_sched #(.NDR(4), .AW(15), .ROM_LAT(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .ph2_f       (ph2_f),
    .drv_en      (drv_en),
    .drv_addr    (drv_addr),
    .rom_sz      (rom_sz),
    .stdrom      (stdrom),
    .rom_a       (rom_a),
    .rom_q       (rom_q),
    .drv_data    (drv_data),
    .drv_valid   (drv_valid),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // ROM model: one cycle latency, content = low address byte.
  always @(posedge clk) rom_q <= rom_a[7:0];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_v(input int idx, input int data, input int t);
    ev_t e;
    e.kind = 0; e.idx = idx; e.data = data; e.t = t;
    sb.push_back(e);
  endtask

  task automatic push_d(input int t);
    ev_t e;
    e.kind = 1; e.idx = 0; e.data = 0; e.t = t;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input int idx, input int data);
    ev_t e;
    nchk++;
    if (sb.size() == 0) begin
      nerr++;
      $display("FAIL sb_unexpected: got kind=%0d idx=%0d data=0x%0h at cycle %0d, expected nothing",
               kind, idx, data, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.idx != idx || e.data != data || e.t != cyc) begin
        nerr++;
        $display("FAIL sb_event: got kind=%0d idx=%0d data=0x%0h t=%0d expected kind=%0d idx=%0d data=0x%0h t=%0d",
                 kind, idx, data, cyc, e.kind, e.idx, e.data, e.t);
      end
    end
  endtask

  // Monitor: every valid pulse and done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) if (drv_valid[i]) observe(0, i, int'(drv_data[i]));
      if (done) observe(1, 0, 0);
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after T0 with T0 in t0.
  task automatic kick(input logic [3:0] en, input int a0, input int a1, input int a2, input int a3,
                      output int t0);
    drv_en = en;
    drv_addr[0] = 15'(a0); drv_addr[1] = 15'(a1); drv_addr[2] = 15'(a2); drv_addr[3] = 15'(a3);
    ph2_f = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    ph2_f = 1'b0;
  endtask

  task automatic chk_sb_empty(input string name);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_rom_a"}, int'(rom_a), 0);
    for (int i = 0; i < 4; i++) chk({name, "_data"}, int'(drv_data[i]), 0);
    chk({name, "_valid"}, int'(drv_valid), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_ovr"}, int'(overrun), 0);
    chk({name, "_cnt"}, int'(overrun_cnt), 0);
  endtask

  int t0;
  int mask_tbl [5][4] = '{
    '{0, 0, 'h7FFF, 'h1FFF},
    '{0, 1, 'h7FFF, 'h3FFF},
    '{1, 0, 'h7FFF, 'h3FFF},
    '{3, 0, 'h7FFF, 'h7FFF},
    '{1, 0, 'h5ABC, 'h1ABC}
  };

  initial begin
    for (int i = 0; i < 4; i++) drv_addr[i] = 15'h0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // All four drives, snapshot must ignore later address changes.
    rom_sz = 2'b11; stdrom = 1'b0;
    kick(4'b1111, 'h10, 'h20, 'h30, 'h40, t0);
    for (int i = 0; i < 4; i++) drv_addr[i] = 15'h7777;
    drv_en = 4'b0000;
    for (int j = 0; j < 4; j++) push_v(j, 'h10 * (j + 1), t0 + 3 + j);
    push_d(t0 + 7);
    chk("busy_t0", int'(busy), 1);
    wait_to(t0 + 6);
    chk("busy_t6", int'(busy), 1);
    wait_to(t0 + 7);
    chk("busy_t7", int'(busy), 0);
    wait_to(t0 + 10);
    chk_sb_empty("sb_round_all");

    // Sparse enable: drives 1 and 3 only.
    kick(4'b1010, 'h55, 'h66, 'h77, 'h88, t0);
    push_v(1, 'h66, t0 + 3);
    push_v(3, 'h88, t0 + 4);
    push_d(t0 + 5);
    wait_to(t0 + 8);
    chk_sb_empty("sb_round_sparse");
    chk("keep_d0", int'(drv_data[0]), 'h10);
    chk("keep_d2", int'(drv_data[2]), 'h30);
    chk("new_d3", int'(drv_data[3]), 'h88);

    // Address mask variants.
    for (int k = 0; k < 5; k++) begin
      rom_sz = 2'(mask_tbl[k][0]);
      stdrom = 1'(mask_tbl[k][1]);
      kick(4'b0001, mask_tbl[k][2], 0, 0, 0, t0);
      push_v(0, mask_tbl[k][3] & 'hFF, t0 + 3);
      push_d(t0 + 4);
      @(negedge clk);
      chk("mask_rom_a", int'(rom_a), mask_tbl[k][3]);
      wait_to(t0 + 6);
    end
    chk_sb_empty("sb_mask");

    // No drives enabled.
    rom_sz = 2'b11; stdrom = 1'b0;
    kick(4'b0000, 'h11, 'h12, 'h13, 'h14, t0);
    push_d(t0 + 1);
    wait_to(t0 + 4);
    chk_sb_empty("sb_zero_en");
    chk("zero_rom_a", int'(rom_a), 'h1ABC);
    chk("zero_keep_d0", int'(drv_data[0]), 'hBC);

    // Abort: second ph2_f lands at T2 and restarts with fresh addresses.
    kick(4'b1111, 'h01, 'h02, 'h03, 'h04, t0);
    @(negedge clk);
    kick(4'b1111, 'hA1, 'hA2, 'hA3, 'hA4, t0);
    for (int j = 0; j < 4; j++) push_v(j, 'hA1 + j, t0 + 3 + j);
    push_d(t0 + 7);
    wait_to(t0 + 10);
    chk_sb_empty("sb_abort");
    chk("abort_ovr", int'(overrun), OVR_EN ? 1 : 0);
    chk("abort_cnt", int'(overrun_cnt), OVR_EN ? 1 : 0);

    // 300 back-to-back aborts saturate the counter.
    drv_en = 4'b0001; drv_addr[0] = 15'h0042;
    ph2_f = 1'b1;
    repeat (301) @(negedge clk);
    ph2_f = 1'b0;
    t0 = cyc;
    push_v(0, 'h42, t0 + 3);
    push_d(t0 + 4);
    wait_to(t0 + 7);
    chk_sb_empty("sb_storm");
    chk("storm_ovr", int'(overrun), OVR_EN ? 1 : 0);
    chk("storm_cnt", int'(overrun_cnt), OVR_EN ? 'hFF : 0);

    // Reset in the middle of a round.
    kick(4'b1111, 'h21, 'h22, 'h23, 'h24, t0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk_sb_empty("sb_midrst");
    kick(4'b0110, 'h31, 'h32, 'h33, 'h34, t0);
    push_v(1, 'h32, t0 + 3);
    push_v(2, 'h33, t0 + 4);
    push_d(t0 + 5);
    wait_to(t0 + 8);
    chk_sb_empty("sb_post_rst");
    chk("post_rst_d0", int'(drv_data[0]), 0);
    chk("post_rst_d2", int'(drv_data[2]), 'h33);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
